nonce_dispatcher: RTL
=====================

# nonce_dispatcher

Scheduler that shares a pool of `NUM_CORES` SHA-256 double-hash cores across a nonce sweep. It hands out nonces 0..`NUM_NONCES-1` to idle cores and collects finished hashes through a round-robin arbiter. Each result is written, one word per cycle, into the shared result memory at `output_addr + nonce`. It sits between the top-level start/done handshake and the hash cores, and it owns the memory write port.

## Interface
- `NUM_CORES`, 4: number of hash cores served; 1..16.
- `NUM_NONCES`, 16: nonces swept per run; 1..65535.
- `clk` in 1: sole clock; also drives the memory clock.
- `reset` in 1: asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `start` in 1: level-sampled; begins a sweep when in IDLE or DONE.
- `output_addr` in 16: result base address; captured on accepted `start`.
- `done` out 1: high while in DONE.
- `core_start` out `NUM_CORES`: one-hot, one-cycle pulse that dispatches `core_nonce` to core i.
- `core_nonce` out 32: nonce, valid with `core_start`; zero-extended.
- `core_valid` in `NUM_CORES`: core i holds its result; level, held until acknowledged.
- `core_hash` in `32*NUM_CORES`: h0 of core i in bits [32i+31:32i].
- `core_ack` out `NUM_CORES`: one-hot, one-cycle pulse; core i drops `core_valid` on the following edge.
- `mem_we` out 1: write strobe, one cycle per result.
- `mem_addr` out 16: write address.
- `mem_write_data` out 32: write data.

## Operation
- States IDLE, RUN, DONE.
  - IDLE→RUN on `start`.
  - RUN→DONE when issued count = written count = `NUM_NONCES`.
  - DONE→RUN on `start`.
  - `start` is ignored in RUN.
- Accepting `start`: capture `output_addr`, clear the issued/written counters, clear busy[], and reset the round-robin pointer to 0.
- Per-core state:
  - busy[i] and nonce_reg[i], where nonce_reg is `$clog2(NUM_NONCES)` bits wide, minimum 1.
  - Counters are `$clog2(NUM_NONCES+1)` bits wide.
- Dispatch, at most one per cycle, in RUN only:
  - If issued < `NUM_NONCES`, select the lowest-index core with busy=0.
  - Pulse `core_start[i]` with `core_nonce`=issued.
  - Set busy[i], store nonce_reg[i], and increment issued.
- Collect, at most one per cycle:
  - Eligible cores have `core_valid[i]` & busy[i] & ~`core_ack[i]`.
  - Grant is round-robin, searching from the pointer.
  - On grant: `mem_we`=1, `mem_addr`=base + nonce_reg[i] (16-bit wrap), `mem_write_data`=hash i, `core_ack[i]`=1.
  - Also on grant: clear busy[i], increment written, and set the pointer to i+1 mod `NUM_CORES`.
- A core freed by a grant is dispatchable from the next cycle, never on the same edge.
- Dispatch and collect to different cores may occur on the same edge.
- `core_valid` from a non-busy core is ignored: no write, no ack.

## Timing
- Reset values:
  - state IDLE.
  - `done`, `core_start`, `core_ack`, `mem_we`, `mem_addr`, `mem_write_data`, `core_nonce` all 0.
  - Counters, busy[] and pointer 0.
- All outputs are registered.
- Start latency:
  - `start` sampled at edge E0.
  - `core_start[0]` with nonce 0 at E1.
  - core k gets nonce k at E(k+1).
- Result latency: `core_valid[i]` first seen high before edge E, with no contention, gives `mem_we`/`core_ack[i]` high for the cycle after E.
- Contention: N simultaneous valids drain in N consecutive cycles in round-robin order.
- Completion: final `mem_we` at edge Ew, then `done`=1 at Ew+1.
- Restart timing:
  - `start` held in DONE re-enters RUN at the next edge.
  - `done` drops on that same edge.
- Reset mid-RUN returns to IDLE immediately. In-flight core results are discarded; the cores must be reset in parallel.
- `NUM_NONCES` < `NUM_CORES`: only cores 0..`NUM_NONCES-1` are ever started.

## Structure
- Package `nonce_dispatch_pkg` holds:
  - the state enum (logic [1:0]);
  - default localparams `NUM_CORES_DEF`=4 and `NUM_NONCES_DEF`=16;
  - the 32-bit result word typedef.
- Sub-module `rr_arbiter`:
  - parameter N;
  - inputs: request vector, pointer;
  - outputs: one-hot grant, grant index, any-grant;
  - purely combinational.
- All other logic stays in `nonce_dispatcher`.

## Test plan
- Basic sweep, 4 cores/16 nonces, each core answers 70 cycles after its start with hash = 0xA5000000|nonce, output_addr=0x0100:
  - 16 writes to 0x0100..0x010F with the matching data;
  - `done`=1 one cycle after the last write.
- Contention, all 4 cores valid on the same cycle, pointer at 2:
  - writes in core order 2,3,0,1 on 4 consecutive cycles;
  - each `core_ack` is a single pulse.
- `NUM_NONCES`=3, `NUM_CORES`=4: core 3 never sees `core_start`; 3 writes, then `done`.
- Spurious `core_valid[1]` before any dispatch: no `mem_we`, no `core_ack`.
- Reset asserted mid-sweep after 5 writes:
  - all outputs read 0 in the same cycle;
  - a subsequent `start` performs a full 16-write sweep from nonce 0.
- Address wrap, output_addr=0xFFFE, 4 nonces: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/nonce_dispatcher_pkg.sv
// Shared types and defaults for the nonce dispatcher and its arbiter.
package nonce_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } disp_state_t;

  localparam int NUM_CORES_DEF  = 4;
  localparam int NUM_NONCES_DEF = 16;

  // First output word (h0) of a double-hash core.
  typedef logic [31:0] hash_word_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
  import nonce_dispatch_pkg::*;
#(
  parameter  int N  = NUM_CORES_DEF,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx,
  output logic          any_grant
);

  logic [PW-1:0] idx;

  // Walk the request vector starting from the pointer, wrapping at N.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(ptr) + k) % N);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant_idx  = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_dispatcher.sv
// Hands out nonces to idle hash cores and writes their results to memory.
module nonce_dispatcher
  import nonce_dispatch_pkg::*;
#(
  parameter int NUM_CORES  = NUM_CORES_DEF,
  parameter int NUM_NONCES = NUM_NONCES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [31:0]             core_nonce,
  input  logic [NUM_CORES-1:0]    core_valid,
  input  logic [32*NUM_CORES-1:0] core_hash,
  output logic [NUM_CORES-1:0]    core_ack,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int PW = idx_width(NUM_CORES);
  localparam int NW = idx_width(NUM_NONCES);
  localparam int CW = $clog2(NUM_NONCES + 1);
  localparam logic [CW-1:0] NONCE_TOTAL = CW'(NUM_NONCES);

  disp_state_t          state;
  disp_state_t          next_state;
  logic                 start_accept;

  logic [15:0]          base_addr;
  logic [CW-1:0]        issued;
  logic [CW-1:0]        written;
  logic [NUM_CORES-1:0] busy;
  logic [NW-1:0]        nonce_reg [NUM_CORES];
  logic [PW-1:0]        rr_ptr;

  hash_word_t           hash_word [NUM_CORES];

  logic                 disp_found;
  logic                 disp_fire;
  logic [PW-1:0]        disp_idx;

  logic [NUM_CORES-1:0] collect_req;
  logic [NUM_CORES-1:0] grant;
  logic [PW-1:0]        grant_idx;
  logic                 any_grant;
  logic [PW-1:0]        ptr_after;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: start only accepted outside RUN; finish once every nonce is written back.
  always_comb begin
    next_state   = state;
    start_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state   = ST_RUN;
          start_accept = 1'b1;
        end
      end
      ST_RUN: begin
        if (issued == NONCE_TOTAL && written == NONCE_TOTAL) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state   = ST_RUN;
          start_accept = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Split the packed hash bus into per-core words.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      hash_word[i] = core_hash[32*i +: 32];
    end
  end

  // Dispatch target: lowest-index idle core, while nonces remain.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!disp_found && !busy[i]) begin
        disp_found = 1'b1;
        disp_idx   = PW'(i);
      end
    end
    disp_fire = (state == ST_RUN) && (issued < NONCE_TOTAL) && disp_found;
  end

  // Collect requests: only busy cores not already being acknowledged this cycle.
  always_comb begin
    collect_req = '0;
    if (state == ST_RUN) begin
      collect_req = core_valid & busy & ~core_ack;
    end
    ptr_after = (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
  end

  rr_arbiter #(
    .N (NUM_CORES)
  ) u_rr_arbiter (
    .req       (collect_req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // Datapath: counters, per-core bookkeeping and registered outputs.
  // A dispatch and a grant never target the same core (idle vs busy), so both
  // busy[] updates can land on the same edge without conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_addr      <= '0;
      issued         <= '0;
      written        <= '0;
      busy           <= '0;
      rr_ptr         <= '0;
      done           <= 1'b0;
      core_start     <= '0;
      core_nonce     <= '0;
      core_ack       <= '0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        nonce_reg[i] <= '0;
      end
    end else begin
      core_start <= '0;
      core_ack   <= '0;
      mem_we     <= 1'b0;
      done       <= (next_state == ST_DONE);
      if (start_accept) begin
        base_addr <= output_addr;
        issued    <= '0;
        written   <= '0;
        busy      <= '0;
        rr_ptr    <= '0;
      end else begin
        if (disp_fire) begin
          core_start[disp_idx] <= 1'b1;
          core_nonce           <= 32'(issued);
          busy[disp_idx]       <= 1'b1;
          nonce_reg[disp_idx]  <= NW'(issued);
          issued               <= issued + 1'b1;
        end
        if (any_grant) begin
          mem_we          <= 1'b1;
          mem_addr        <= base_addr + 16'(nonce_reg[grant_idx]);
          mem_write_data  <= hash_word[grant_idx];
          core_ack        <= grant;
          busy[grant_idx] <= 1'b0;
          written         <= written + 1'b1;
          rr_ptr          <= ptr_after;
        end
      end
    end
  end

endmodule
